// File: rtl/grad_update.sv
// Squared-error backward pass: forms dL/dw_k = 2*(pred - target)*x_k and applies
// a shift-scaled SGD step to an internal weight file, one weight per cycle.
module grad_update #(
  parameter int N_IN     = 4,
  parameter int X_W      = 4,
  parameter int W_W      = 8,
  parameter int PRED_W   = 21,
  parameter int LR_SHIFT = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   start_i,
  input  logic                   load_i,
  input  logic [3:0]             target_i,
  input  logic [PRED_W-1:0]      predicted_i,
  input  logic [N_IN*X_W-1:0]    x_i,
  input  logic [N_IN*W_W-1:0]    w_load_i,
  output logic [N_IN*W_W-1:0]    weights_o,
  output logic [PRED_W:0]        err_o,
  output logic                   busy_o,
  output logic                   done_o
);

  localparam int T_W = 4;
  localparam int IW  = (N_IN > 1) ? $clog2(N_IN) : 1;
  localparam int GW  = PRED_W + X_W + 2;
  localparam int DW  = ((GW > W_W) ? GW : W_W) + 1;

  localparam logic signed [DW-1:0] W_MAX = DW'((2 ** (W_W - 1)) - 1);
  localparam logic signed [DW-1:0] W_MIN = DW'(-(2 ** (W_W - 1)));

  typedef enum logic [1:0] {
    S_IDLE,
    S_ERR,
    S_UPD,
    S_DONE
  } state_t;

  state_t                   state;
  logic [IW-1:0]            idx;
  logic [T_W-1:0]           tgt_q;
  logic [PRED_W-1:0]        pred_q;
  logic [N_IN*X_W-1:0]      x_q;
  logic [N_IN*W_W-1:0]      w_q;
  logic [PRED_W:0]          err_q;
  logic                     done_q;

  logic [X_W-1:0]           x_sel;
  logic [W_W-1:0]           w_sel;
  logic signed [GW-1:0]     err_ext;
  logic signed [GW-1:0]     x_ext;
  logic signed [GW-1:0]     prod;
  logic signed [GW-1:0]     grad;
  logic signed [GW-1:0]     delta;
  logic signed [DW-1:0]     w_ext;
  logic signed [DW-1:0]     delta_ext;
  logic signed [DW-1:0]     diff;
  logic [W_W-1:0]           w_new;

  assign weights_o = w_q;
  assign err_o     = err_q;
  assign done_o    = done_q;
  assign busy_o    = (state != S_IDLE);

  // Datapath for the weight selected by idx; x is unsigned, so it is zero-extended
  // before the signed multiply to keep the product exact.
  // NOTE: every always_comb output gets a default first so no latch can be inferred.
  always_comb begin
    x_sel     = x_q[idx*X_W +: X_W];
    w_sel     = w_q[idx*W_W +: W_W];
    err_ext   = {{(GW-PRED_W-1){err_q[PRED_W]}}, err_q};
    x_ext     = {{(GW-X_W){1'b0}}, x_sel};
    prod      = err_ext * x_ext;
    grad      = prod <<< 1;
    delta     = grad >>> LR_SHIFT;
    w_ext     = {{(DW-W_W){w_sel[W_W-1]}}, w_sel};
    delta_ext = {{(DW-GW){delta[GW-1]}}, delta};
    diff      = w_ext - delta_ext;
    w_new     = diff[W_W-1:0];
    if (diff > W_MAX) begin
      w_new = W_MAX[W_W-1:0];
    end else if (diff < W_MIN) begin
      w_new = W_MIN[W_W-1:0];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the pre-edge value of every other register.
  // NOTE: the weight file is small and must read as zero after reset, so it is
  // reset like any other register rather than left uninitialised.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state  <= S_IDLE;
      idx    <= '0;
      tgt_q  <= '0;
      pred_q <= '0;
      x_q    <= '0;
      w_q    <= '0;
      err_q  <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (load_i) begin
            w_q <= w_load_i;
          end else if (start_i) begin
            tgt_q  <= target_i;
            pred_q <= predicted_i;
            x_q    <= x_i;
            state  <= S_ERR;
          end
        end
        S_ERR: begin
          err_q <= {1'b0, pred_q} - {{(PRED_W+1-T_W){1'b0}}, tgt_q};
          idx   <= '0;
          state <= S_UPD;
        end
        S_UPD: begin
          w_q[idx*W_W +: W_W] <= w_new;
          if (idx == IW'(N_IN - 1)) begin
            idx    <= '0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end else begin
            idx <= idx + IW'(1);
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_grad_update.sv
// Directed bench for grad_update: expected step results are queued when a start is
// driven and compared when done_o pulses; other checks are inline.
module tb_grad_update;

  localparam int N_IN     = 4;
  localparam int X_W      = 4;
  localparam int W_W      = 8;
  localparam int PRED_W   = 21;
  localparam int LR_SHIFT = 4;

  typedef struct {
    logic [PRED_W:0]     err;
    logic [N_IN*W_W-1:0] w;
  } exp_t;

  logic                  clk_i;
  logic                  rst_i;
  logic                  start_i;
  logic                  load_i;
  logic [3:0]            target_i;
  logic [PRED_W-1:0]     predicted_i;
  logic [N_IN*X_W-1:0]   x_i;
  logic [N_IN*W_W-1:0]   w_load_i;
  logic [N_IN*W_W-1:0]   weights_o;
  logic [PRED_W:0]       err_o;
  logic                  busy_o;
  logic                  done_o;

  int   vectors;
  int   miscompares;
  int   mw[N_IN];
  exp_t sb[$];

  grad_update #(
    .N_IN(N_IN), .X_W(X_W), .W_W(W_W), .PRED_W(PRED_W), .LR_SHIFT(LR_SHIFT)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .start_i(start_i),
    .load_i(load_i),
    .target_i(target_i),
    .predicted_i(predicted_i),
    .x_i(x_i),
    .w_load_i(w_load_i),
    .weights_o(weights_o),
    .err_o(err_o),
    .busy_o(busy_o),
    .done_o(done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N_IN*X_W-1:0] pack_x(input int xs[N_IN]);
    logic [N_IN*X_W-1:0] v;
    v = '0;
    for (int k = 0; k < N_IN; k++) v[k*X_W +: X_W] = X_W'(xs[k]);
    return v;
  endfunction

  function automatic logic [N_IN*W_W-1:0] model_vec();
    logic [N_IN*W_W-1:0] v;
    for (int k = 0; k < N_IN; k++) v[k*W_W +: W_W] = mw[k][W_W-1:0];
    return v;
  endfunction

  // Reference step on the shadow weights: floor division instead of shifting.
  task automatic model_step(input int pred, input int tgt, input int xs[N_IN], output exp_t ex);
    longint e, g, d, n, div, wmax, wmin;
    div  = longint'(1) << LR_SHIFT;
    wmax = (longint'(1) << (W_W - 1)) - 1;
    wmin = -(longint'(1) << (W_W - 1));
    e = longint'(pred) - longint'(tgt);
    for (int k = 0; k < N_IN; k++) begin
      g = 2 * e * longint'(xs[k]);
      d = (g >= 0) ? g / div : -((-g + div - 1) / div);
      n = longint'(mw[k]) - d;
      if (n > wmax) n = wmax;
      if (n < wmin) n = wmin;
      mw[k] = int'(n);
    end
    ex.err = e[PRED_W:0];
    ex.w   = model_vec();
  endtask

  task automatic load_weights(input logic [N_IN*W_W-1:0] v);
    load_i   = 1'b1;
    w_load_i = v;
    @(negedge clk_i);
    load_i   = 1'b0;
    w_load_i = N_IN*W_W'($urandom);
    for (int k = 0; k < N_IN; k++) mw[k] = int'($signed(v[k*W_W +: W_W]));
    check("load_weights", 64'(weights_o), 64'(v));
  endtask

  task automatic run_step(input int pred, input int tgt, input int xs[N_IN], input bit disturb);
    int   c;
    exp_t ex;
    exp_t got;
    model_step(pred, tgt, xs, ex);
    sb.push_back(ex);
    predicted_i = PRED_W'(pred);
    target_i    = 4'(tgt);
    x_i         = pack_x(xs);
    start_i     = 1'b1;
    @(negedge clk_i);
    start_i     = 1'b0;
    predicted_i = PRED_W'($urandom);
    target_i    = 4'($urandom);
    x_i         = N_IN*X_W'($urandom);
    check("busy_after_start", 64'(busy_o), 64'(1));
    c = 0;
    while (!done_o && c < 20) begin
      if (disturb) begin
        if (c == 0) begin load_i = 1'b1; w_load_i = N_IN*W_W'($urandom); end
        if (c == 1) load_i = 1'b0;
        if (c == 2) start_i = 1'b1;
        if (c == 3) start_i = 1'b0;
      end
      @(negedge clk_i);
      c++;
    end
    load_i  = 1'b0;
    start_i = 1'b0;
    check("done_latency", 64'(c), 64'(N_IN + 1));
    check("busy_in_done", 64'(busy_o), 64'(1));
    check("sb_nonempty", 64'(sb.size() > 0), 64'(1));
    if (sb.size() > 0) begin
      got = sb.pop_front();
      check("step_err", 64'(err_o), 64'(got.err));
      check("step_weights", 64'(weights_o), 64'(got.w));
    end
    @(negedge clk_i);
    check("done_one_cycle", 64'(done_o), 64'(0));
    check("idle_after_done", 64'(busy_o), 64'(0));
    check("err_hold", 64'(err_o), 64'(ex.err));
  endtask

  initial begin
    int   xs[N_IN];
    int   c;
    exp_t ex;
    logic [N_IN*W_W-1:0] v;

    vectors = 0;
    miscompares = 0;
    rst_i = 1'b0;
    start_i = 1'b0;
    load_i = 1'b0;
    target_i = '0;
    predicted_i = '0;
    x_i = '0;
    w_load_i = '0;
    for (int k = 0; k < N_IN; k++) mw[k] = 0;
    repeat (2) @(negedge clk_i);
    check("rst_weights", 64'(weights_o), 64'(0));
    check("rst_err", 64'(err_o), 64'(0));
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    rst_i = 1'b1;
    @(negedge clk_i);

    // Basic step: err 8, x=1 -> each weight -1.
    xs = '{1, 1, 1, 1};
    run_step(10, 2, xs, 1'b0);
    check("basic_w0", 64'(weights_o[W_W-1:0]), 64'(8'hFF));

    // Negative error, floor rounding: delta -29 -> +29.
    load_weights('0);
    xs = '{15, 15, 15, 15};
    run_step(0, 15, xs, 1'b0);
    check("neg_err", 64'(err_o), 64'(22'h3FFFF1));
    check("neg_w3", 64'(weights_o[3*W_W +: W_W]), 64'(8'd29));

    // Saturation at both rails.
    load_weights({N_IN{8'h80}});
    run_step(1000, 0, xs, 1'b0);
    check("sat_low", 64'(weights_o), 64'({N_IN{8'h80}}));
    load_weights({N_IN{8'h7F}});
    run_step(0, 15, xs, 1'b0);
    check("sat_high", 64'(weights_o), 64'({N_IN{8'h7F}}));

    // Load during ERR and start during UPD are ignored.
    load_weights(32'h10F0_2005);
    xs = '{3, 0, 7, 1};
    run_step(20, 9, xs, 1'b1);
    repeat (3) @(negedge clk_i);
    check("no_restart_busy", 64'(busy_o), 64'(0));
    check("no_restart_w", 64'(weights_o), 64'(model_vec()));

    // Load wins over start in the same IDLE cycle.
    v = 32'hA1B2_C3D4;
    load_i = 1'b1;
    start_i = 1'b1;
    w_load_i = v;
    predicted_i = 21'd500;
    target_i = 4'd1;
    x_i = '1;
    @(negedge clk_i);
    load_i = 1'b0;
    start_i = 1'b0;
    for (int k = 0; k < N_IN; k++) mw[k] = int'($signed(v[k*W_W +: W_W]));
    check("load_start_busy", 64'(busy_o), 64'(0));
    check("load_start_w", 64'(weights_o), 64'(v));
    repeat (6) @(negedge clk_i);
    check("load_start_nostep", 64'(done_o | busy_o), 64'(0));

    // Zero error leaves weights unchanged.
    xs = '{15, 9, 4, 1};
    run_step(7, 7, xs, 1'b0);
    check("zero_err_w", 64'(weights_o), 64'(v));

    // Mixed x with err 8: deltas {0,1,2,3}.
    load_weights('0);
    xs = '{0, 1, 2, 3};
    run_step(10, 2, xs, 1'b0);
    check("mixed_w", 64'(weights_o), 64'({8'hFD, 8'hFE, 8'hFF, 8'h00}));

    // Random steps, including large predictions.
    for (int i = 0; i < 4; i++) begin
      load_weights(N_IN*W_W'($urandom));
      for (int k = 0; k < N_IN; k++) xs[k] = int'($urandom_range(0, 15));
      run_step(int'($urandom_range(0, (i < 2) ? 40 : 2097151)), int'($urandom_range(0, 15)), xs, 1'b0);
    end

    // Reset mid-UPD after two weights were written.
    load_weights(32'h0102_0304);
    xs = '{15, 15, 15, 15};
    model_step(300, 3, xs, ex);
    predicted_i = 21'd300;
    target_i = 4'd3;
    x_i = pack_x(xs);
    start_i = 1'b1;
    @(negedge clk_i);
    start_i = 1'b0;
    for (c = 0; c < 3; c++) @(negedge clk_i);
    check("partial_w0", 64'(weights_o[W_W-1:0]), 64'(ex.w[W_W-1:0]));
    check("partial_w2", 64'(weights_o[2*W_W +: W_W]), 64'(8'h02));
    rst_i = 1'b0;
    #1;
    check("midrst_weights", 64'(weights_o), 64'(0));
    check("midrst_err", 64'(err_o), 64'(0));
    check("midrst_busy", 64'(busy_o), 64'(0));
    check("midrst_done", 64'(done_o), 64'(0));
    for (int k = 0; k < N_IN; k++) mw[k] = 0;
    @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    xs = '{2, 5, 1, 4};
    run_step(33, 6, xs, 1'b0);

    check("sb_drained", 64'(sb.size()), 64'(0));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
